alu_result_serializer: RTL and testbench

Downstream stage of the 16-bit logic ALU. Captures one ALU result and its 3-bit function code through a valid/ready handshake. Transmits them as a single framed serial word on a one-wire output: start bit, func, data MSB-first, parity, stop bit. Gives the ALU datapath a pin-cheap result port for test and debug.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/bit_tick_gen.sv | 35 +++
 rtl/alu_result_serializer.sv | 129 ++++++++++++
 tb/tb_alu_result_serializer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Purpose: shared ALU definitions, including the func codes, frame geometry and serializer FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [2:0] FUNC_NOT  = 3'b001;
    localparam logic [2:0] FUNC_AND  = 3'b010;
    localparam logic [2:0] FUNC_OR   = 3'b011;
    localparam logic [2:0] FUNC_XOR  = 3'b100;
    localparam logic [2:0] FUNC_XNOR = 3'b101;
    localparam logic [2:0] FUNC_NOR  = 3'b110;
    localparam logic [2:0] FUNC_NAND = 3'b111;

    localparam int FUNC_BITS  = 3;
    localparam int DATA_BITS  = 16;
    localparam int FRAME_BITS = 22;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_FUNC   = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } ser_state_t;

    // Parity covers func and data; odd_sel flips even parity to odd parity.
    function automatic logic frame_parity(input logic [FUNC_BITS-1:0] f,
                                          input logic [DATA_BITS-1:0] r,
                                          input logic odd_sel);
        return (^{f, r}) ^ odd_sel;
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Purpose: bit-period timer; tick marks the last cycle of each bit period, and pre_tick marks the cycle before it.
// Latency: tick is decoded from the count register. The count restarts from zero on the first cycle with en high.
// Backpressure: none; the timer free-runs while en is high.
module bit_tick_gen #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick,
    output logic pre_tick
);

    localparam int            CW      = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
    localparam bit            HAS_PRE = (CLKS_PER_BIT > 1);
    localparam logic [CW-1:0] PRE     = HAS_PRE ? CW'(CLKS_PER_BIT - 2) : '0;

    logic [CW-1:0] cnt;

    // The count is held at zero while disabled, so each frame starts a fresh period.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick     = en && (cnt == LAST);
    assign pre_tick = en && HAS_PRE && (cnt == PRE);

endmodule

// File: rtl/alu_result_serializer.sv
// Purpose: captures one ALU result and its func code, then shifts out the frame: start, func, data, parity, stop.
// Latency: the start bit appears one cycle after the handshake; a frame lasts 22*CLKS_PER_BIT cycles, followed by one idle cycle.
// Backpressure: in_ready is high only in IDLE; in_valid is ignored while a frame is in flight.
module alu_result_serializer
    import alu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter bit ODD_PARITY   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] res,
    input  logic [FUNC_BITS-1:0] func,
    output logic                 sdo,
    output logic                 busy,
    output logic                 done
);

    localparam int SH_W = FUNC_BITS + DATA_BITS;

    ser_state_t      state;
    logic [SH_W-1:0] shreg;
    logic            par;
    logic [3:0]      bit_idx;
    logic            tick;
    logic            pre_tick;
    logic            tick_en;
    logic            done_set;

    assign tick_en  = (state != ST_IDLE);
    assign in_ready = (state == ST_IDLE);

    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .en      (tick_en),
        .tick    (tick),
        .pre_tick(pre_tick)
    );

    // done is registered, so it is set one cycle early: on entry to the final STOP cycle.
    always_comb begin
        done_set = 1'b0;
        if (CLKS_PER_BIT == 1) begin
            done_set = (state == ST_PARITY) && tick;
        end else begin
            done_set = (state == ST_STOP) && pre_tick;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            sdo     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            shreg   <= '0;
            par     <= 1'b0;
            bit_idx <= '0;
        end else begin
            done <= done_set;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state <= ST_START;
                        shreg <= {func, res};
                        par   <= frame_parity(func, res, ODD_PARITY);
                        sdo   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state   <= ST_FUNC;
                        sdo     <= shreg[SH_W-1];
                        shreg   <= {shreg[SH_W-2:0], 1'b0};
                        bit_idx <= 4'(FUNC_BITS - 1);
                    end
                end
                ST_FUNC: begin
                    if (tick) begin
                        sdo   <= shreg[SH_W-1];
                        shreg <= {shreg[SH_W-2:0], 1'b0};
                        if (bit_idx == 4'd0) begin
                            state   <= ST_DATA;
                            bit_idx <= 4'(DATA_BITS - 1);
                        end else begin
                            bit_idx <= bit_idx - 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == 4'd0) begin
                            state <= ST_PARITY;
                            sdo   <= par;
                        end else begin
                            sdo     <= shreg[SH_W-1];
                            shreg   <= {shreg[SH_W-2:0], 1'b0};
                            bit_idx <= bit_idx - 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state <= ST_STOP;
                        sdo   <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    sdo   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer: three instances cover even parity at 1 clock per bit,
// odd parity at 1 clock per bit, and even parity at 3 clocks per bit.
module tb_alu_result_serializer;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic [15:0] res;
    logic [2:0]  func;
    int          sel;
    int          cpb;
    int          errors = 0;
    int          checks = 0;

    logic iv_a, iv_b, iv_c;
    logic rdy_a, rdy_b, rdy_c;
    logic sdo_a, sdo_b, sdo_c;
    logic busy_a, busy_b, busy_c;
    logic done_a, done_b, done_c;
    logic m_sdo, m_busy, m_done, m_rdy;

    assign iv_a = in_valid && (sel == 0);
    assign iv_b = in_valid && (sel == 1);
    assign iv_c = in_valid && (sel == 2);

    alu_result_serializer #(.CLKS_PER_BIT(1), .ODD_PARITY(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(rdy_a), .res(res), .func(func),
        .sdo(sdo_a), .busy(busy_a), .done(done_a));
    alu_result_serializer #(.CLKS_PER_BIT(1), .ODD_PARITY(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(rdy_b), .res(res), .func(func),
        .sdo(sdo_b), .busy(busy_b), .done(done_b));
    alu_result_serializer #(.CLKS_PER_BIT(3), .ODD_PARITY(1'b0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(rdy_c), .res(res), .func(func),
        .sdo(sdo_c), .busy(busy_c), .done(done_c));

    always_comb begin
        m_sdo = sdo_a; m_busy = busy_a; m_done = done_a; m_rdy = rdy_a;
        case (sel)
            1: begin m_sdo = sdo_b; m_busy = busy_b; m_done = done_b; m_rdy = rdy_b; end
            2: begin m_sdo = sdo_c; m_busy = busy_c; m_done = done_c; m_rdy = rdy_c; end
            default: ;
        endcase
    end

    // Hand-computed frames: start, func, data, parity, stop.
    localparam logic [21:0] F_A5F0_AND  = 22'b0_010_1010_0101_1111_0000_1_1;
    localparam logic [21:0] F_ZERO_ODD  = 22'b0_000_0000_0000_0000_0000_1_1;
    localparam logic [21:0] F_FFFF_NAND = 22'b0_111_1111_1111_1111_1111_1_1;
    localparam logic [21:0] F_0001_OR   = 22'b0_011_0000_0000_0000_0001_1_1;
    localparam logic [21:0] F_8000_XOR  = 22'b0_100_1000_0000_0000_0000_0_1;
    localparam logic [21:0] F_1234_NOT  = 22'b0_001_0001_0010_0011_0100_0_1;
    localparam logic [21:0] F_00FF_XNOR = 22'b0_101_0000_0000_1111_1111_0_1;

    task automatic start_word(input logic [15:0] r, input logic [2:0] f, input string name);
        @(negedge clk);
        res = r; func = f; in_valid = 1'b1;
        checks++;
        if (m_rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: in_ready=%b, expected 1", name, m_rdy);
        end
        @(posedge clk);
        #1;
    endtask

    // Checks every cycle of one frame plus the idle cycle after it; poke_k >= 0 pulses a competing word.
    task automatic check_frame(input logic [21:0] exp, input string name, input int poke_k);
        logic [21:0] fr;
        logic [3:0]  got, want;
        logic        last;
        fr = exp;
        for (int k = 0; k < 22; k++) begin
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                last = (k == 21) && (c == cpb - 1);
                got  = {m_sdo, m_busy, m_done, m_rdy};
                want = {fr[21-k], 1'b1, last, 1'b0};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL %s bit%0d cyc%0d: {sdo,busy,done,rdy}=%b, expected %b",
                             name, k, c, got, want);
                end
                if (poke_k >= 0 && c == 0) begin
                    if (k == poke_k) begin
                        in_valid = 1'b1; res = 16'h1234; func = FUNC_NOT;
                    end else if (k == poke_k + 1) begin
                        in_valid = 1'b0;
                    end
                end
            end
        end
        @(negedge clk);
        got = {m_sdo, m_busy, m_done, m_rdy};
        checks++;
        if (got !== 4'b1001) begin
            errors++;
            $display("FAIL %s idle: {sdo,busy,done,rdy}=%b, expected 1001", name, got);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; res = '0; func = '0; sel = 0; cpb = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sdo_a, busy_a, done_a, rdy_a} !== 4'b1001) begin
            errors++; $display("FAIL reset_a: got %b, expected 1001", {sdo_a, busy_a, done_a, rdy_a});
        end
        checks++;
        if ({sdo_b, busy_b, done_b, rdy_b} !== 4'b1001) begin
            errors++; $display("FAIL reset_b: got %b, expected 1001", {sdo_b, busy_b, done_b, rdy_b});
        end
        checks++;
        if ({sdo_c, busy_c, done_c, rdy_c} !== 4'b1001) begin
            errors++; $display("FAIL reset_c: got %b, expected 1001", {sdo_c, busy_c, done_c, rdy_c});
        end
        // A reset with in_valid high in the same cycle must capture nothing.
        res = 16'hBEEF; func = FUNC_OR; in_valid = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({sdo_a, busy_a, done_a, rdy_a} !== 4'b1001) begin
                errors++;
                $display("FAIL rst_vs_valid cyc%0d: got %b, expected 1001", i, {sdo_a, busy_a, done_a, rdy_a});
            end
        end
    endtask

    task automatic test_even_parity();
        sel = 0; cpb = 1;
        start_word(16'hA5F0, FUNC_AND, "even");
        in_valid = 1'b0;
        check_frame(F_A5F0_AND, "even", -1);
    endtask

    task automatic test_odd_zero();
        sel = 1; cpb = 1;
        start_word(16'h0000, 3'b000, "oddzero");
        in_valid = 1'b0;
        check_frame(F_ZERO_ODD, "oddzero", -1);
    endtask

    task automatic test_stretch();
        sel = 2; cpb = 3;
        start_word(16'hFFFF, FUNC_NAND, "stretch");
        in_valid = 1'b0;
        check_frame(F_FFFF_NAND, "stretch", -1);
    endtask

    task automatic test_holdoff();
        sel = 0; cpb = 1;
        start_word(16'hA5F0, FUNC_AND, "holdoff");
        in_valid = 1'b0; res = 16'h0F0F; func = FUNC_NOR;
        check_frame(F_A5F0_AND, "holdoff", 8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({m_busy, m_rdy} !== 2'b01) begin
                errors++;
                $display("FAIL holdoff_after cyc%0d: {busy,rdy}=%b, expected 01", i, {m_busy, m_rdy});
            end
        end
    endtask

    task automatic test_back_to_back();
        sel = 0; cpb = 1;
        start_word(16'h0001, FUNC_OR, "b2b_first");
        res = 16'h8000; func = FUNC_XOR;
        check_frame(F_0001_OR, "b2b_first", -1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check_frame(F_8000_XOR, "b2b_second", -1);
    endtask

    task automatic test_reset_mid_frame();
        logic [21:0] fr;
        logic        seen_done;
        sel = 0; cpb = 1; fr = F_1234_NOT;
        start_word(16'h1234, FUNC_NOT, "midrst");
        in_valid = 1'b0;
        // Frame bit 12 carries data bit 7.
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if ({m_sdo, m_busy} !== {fr[21-k], 1'b1}) begin
                errors++;
                $display("FAIL midrst bit%0d: {sdo,busy}=%b, expected %b", k, {m_sdo, m_busy}, {fr[21-k], 1'b1});
            end
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_sdo, m_busy, m_done, m_rdy} !== 4'b1001) begin
            errors++;
            $display("FAIL midrst_after: {sdo,busy,done,rdy}=%b, expected 1001", {m_sdo, m_busy, m_done, m_rdy});
        end
        seen_done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (m_done === 1'b1 || m_busy === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_done: done/busy seen=%b, expected 0", seen_done);
        end
        start_word(16'h00FF, FUNC_XNOR, "postrst");
        in_valid = 1'b0;
        check_frame(F_00FF_XNOR, "postrst", -1);
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_zero();
        test_stretch();
        test_holdoff();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
